// File: rtl/mac_flush_ctrl_if.sv
// Bundle of pipe-activity strobes, flush handshake and status lines shared by
// the MAC end-of-stream controller and the datapath around it.
interface mac_flush_ctrl_if #(
  parameter int LOG2_INTERMEDIATOR_DEPTH = 10
);
  logic                                eof;
  logic                                wr;
  logic                                mult_push;
  logic                                add_issue;
  logic                                add_push;
  logic                                flush_ready;
  logic                                stall;
  logic                                flush_valid;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] flush_row;
  logic                                done;
  logic                                busy;
  logic                                err;

  modport master (
    input  eof, wr, mult_push, add_issue, add_push, flush_ready,
    output stall, flush_valid, flush_row, done, busy, err
  );

  modport slave (
    output eof, wr, mult_push, add_issue, add_push, flush_ready,
    input  stall, flush_valid, flush_row, done, busy, err
  );
endinterface

// File: rtl/mac_flush_ctrl.sv
// End-of-stream sequencer for the MAC: tracks values in flight, waits for the
// pipes to settle after eof, then walks every intermediator row through a flush.
module mac_flush_ctrl #(
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = 10,
  parameter int CNT_WIDTH                = 8,
  parameter int QUIET_CYCLES             = 4
) (
  input  logic            clk,
  input  logic            rst,
  mac_flush_ctrl_if.master bus
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [LOG2_INTERMEDIATOR_DEPTH-1:0] LAST_ROW =
    LOG2_INTERMEDIATOR_DEPTH'(INTERMEDIATOR_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  state_e                              state_q, state_d;
  logic [CNT_WIDTH-1:0]                mcnt_q, mcnt_d;
  logic [CNT_WIDTH-1:0]                acnt_q, acnt_d;
  logic [QW-1:0]                       q_q, q_d;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row_q, row_d;
  logic                                err_q, err_d;

  logic stall;
  logic pipe_quiet;
  logic mcnt_err, acnt_err;

  // Returns {error, next count}; a blocked over/underflow keeps the old count.
  function automatic logic [CNT_WIDTH:0] bump(input logic [CNT_WIDTH-1:0] c,
                                              input logic inc,
                                              input logic dec);
    logic [CNT_WIDTH:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CNT_MAX) r[CNT_WIDTH] = 1'b1;
      else              r = {1'b0, c + CNT_WIDTH'(1)};
    end else if (dec && !inc) begin
      if (c == '0) r[CNT_WIDTH] = 1'b1;
      else         r = {1'b0, c - CNT_WIDTH'(1)};
    end
    return r;
  endfunction

  assign stall      = (state_q != ST_RUN);
  assign pipe_quiet = (mcnt_q == '0) && (acnt_q == '0) &&
                      !(bus.wr || bus.mult_push || bus.add_issue || bus.add_push);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    row_d   = row_q;
    {mcnt_err, mcnt_d} = bump(mcnt_q, bus.wr, bus.mult_push);
    {acnt_err, acnt_d} = bump(acnt_q, bus.add_issue, bus.add_push);
    err_d = err_q | mcnt_err | acnt_err | (bus.wr & stall);

    case (state_q)
      ST_RUN: begin
        if (bus.eof) begin
          state_d = ST_DRAIN;
          q_d     = '0;
        end
      end
      ST_DRAIN: begin
        if (!pipe_quiet) begin
          q_d = '0;
        end else if (q_q == QUIET_LAST) begin
          state_d = ST_FLUSH;
          q_d     = '0;
          row_d   = '0;
        end else begin
          q_d = q_q + QW'(1);
        end
      end
      ST_FLUSH: begin
        // The row register parks at 0 once the last row is accepted.
        if (bus.flush_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + LOG2_INTERMEDIATOR_DEPTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      mcnt_q  <= '0;
      acnt_q  <= '0;
      q_q     <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      acnt_q  <= acnt_d;
      q_q     <= q_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.busy        = stall;
  assign bus.flush_valid = (state_q == ST_FLUSH);
  assign bus.flush_row   = row_q;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err         = err_q;

endmodule
